pipe_if_queue: RTL and testbench

PIPE_IF_QUEUE -- requirements
Module: pipe_if_queue

---
 rtl/pipe_if_queue_if.sv | 25 ++
 rtl/pipe_if_queue.sv | 85 ++++++++
 tb/tb_pipe_if_queue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_if_queue_if.sv
// Handshake bundle between the IF stage, the instruction queue and the IF/ID register.
// slave is the queue side, master is the producer/consumer side.
interface pipe_if_queue_if #(
    parameter int AW = 2
);
    logic        in_valid;
    logic [31:0] in_pc4;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic [AW:0] count;

    modport slave (
        input  in_valid, in_pc4, in_inst, out_ready,
        output in_ready, out_valid, out_pc4, out_inst, count
    );

    modport master (
        output in_valid, in_pc4, in_inst, out_ready,
        input  in_ready, out_valid, out_pc4, out_inst, count
    );
endinterface

// File: rtl/pipe_if_queue.sv
// Instruction fetch queue: FIFO of {pc4, inst} between IF and the IF/ID register.
// Define IFQ_BYPASS_EN for zero-latency pass-through when the queue is empty.
module pipe_if_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            flush_i,
    pipe_if_queue_if.slave  q_if
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          stored_valid;
    logic          in_ready;
    logic          push;
    logic          pop;
    logic          bypass_hit;

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = (count_q == '0) && !flush_i && q_if.in_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign stored_valid = (count_q != '0) && !flush_i;
    assign in_ready     = (count_q != FULL) && !flush_i;
    assign pop          = stored_valid && q_if.out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign push         = q_if.in_valid && in_ready && !(bypass_hit && q_if.out_ready);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push && !reset_i) mem_q[wr_ptr_q] <= {q_if.in_pc4, q_if.in_inst};
    end

    always_comb begin
        q_if.out_pc4  = 32'h0;
        q_if.out_inst = 32'h0;
        if (stored_valid) begin
            {q_if.out_pc4, q_if.out_inst} = mem_q[rd_ptr_q];
        end else if (bypass_hit) begin
            q_if.out_pc4  = q_if.in_pc4;
            q_if.out_inst = q_if.in_inst;
        end
    end

    assign q_if.in_ready  = in_ready;
    assign q_if.out_valid = stored_valid || bypass_hit;
    assign q_if.count     = count_q;
endmodule

// File: tb/tb_pipe_if_queue.sv
// Self-checking bench for pipe_if_queue against a queue-based reference model.
module tb_pipe_if_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic fl;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] mq[$];
    bit   model_ok = 1'b0;

    always #5 clk = ~clk;

    pipe_if_queue_if #(.AW(AW)) q_if ();

    pipe_if_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .flush_i (fl),
        .q_if    (q_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, compare outputs with the model mid-cycle, then advance both across one edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        bit          exp_rdy;
        bit          byp;
        bit          has_head;
        logic [63:0] head;
        rst = r; fl = f;
        q_if.in_valid = iv; q_if.in_pc4 = pc; q_if.in_inst = ins; q_if.out_ready = ordy;
        #1;
        exp_rdy  = (mq.size() != DEPTH) && !f;
        byp      = BYP && (mq.size() == 0) && !f && iv;
        has_head = (mq.size() != 0) && !f;
        if (has_head)  head = mq[0];
        else if (byp)  head = {pc, ins};
        else           head = 64'h0;
        if (model_ok) begin
            chk("in_ready",  32'(q_if.in_ready),  32'(exp_rdy));
            chk("out_valid", 32'(q_if.out_valid), 32'(has_head || byp));
            chk("out_pc4",   q_if.out_pc4,        head[63:32]);
            chk("out_inst",  q_if.out_inst,       head[31:0]);
            chk("count",     32'(q_if.count),     32'(mq.size()));
        end
        @(posedge clk);
        if (r || f) begin
            mq.delete();
            if (r) model_ok = 1'b1;
        end else begin
            if (has_head && ordy) void'(mq.pop_front());
            if (iv && exp_rdy && !(byp && ordy)) mq.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    initial begin
        int pushed;
        rst = 1'b1; fl = 1'b0;
        q_if.in_valid = 1'b0; q_if.in_pc4 = '0; q_if.in_inst = '0; q_if.out_ready = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_count", 32'(q_if.count), 32'd0);

        // Fill: 5 pushes into a 4-deep queue with no consumer
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 32'h100 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 0);
        chk("full_count", 32'(q_if.count), 32'd4);
        chk("full_in_ready", 32'(q_if.in_ready), 32'd0);
        chk("full_head_inst", q_if.out_inst, 32'hA000_0000);
        step(0, 0, 0, 0, 0, 0);

        // Push and pop together while full: pop only
        step(0, 0, 1, 32'h200, 32'hBBBB_0001, 1);
        chk("fullpp_count", 32'(q_if.count), 32'd3);
        chk("fullpp_head", q_if.out_inst, 32'hA000_0001);

        // Flush with 3 queued, concurrent push and pop
        step(0, 1, 1, 32'h300, 32'hCCCC_0001, 1);
        chk("flush_count", 32'(q_if.count), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_out_inst", q_if.out_inst, 32'h0);

        // Single instruction with consumer ready
        step(0, 0, 1, 32'h4, 32'h2001_0005, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Reset with two queued and a push active
        step(0, 0, 1, 32'h40, 32'h1111_0001, 0);
        step(0, 0, 1, 32'h44, 32'h1111_0002, 0);
        step(1, 0, 1, 32'h48, 32'h1111_0003, 0);
        chk("rst_count", 32'(q_if.count), 32'd0);
        chk("rst_in_ready", 32'(q_if.in_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0);

        // Stream 10 entries with out_ready toggling, across pointer wrap
        pushed = 0;
        for (int c = 0; c < 40 && (pushed < 10 || mq.size() != 0); c++) begin
            bit rdy_before;
            rdy_before = (mq.size() != DEPTH);
            step(0, 0, pushed < 10, 32'h1000 + 32'(pushed) * 4, $urandom, c[0]);
            if (pushed < 10 && rdy_before) pushed++;
        end
        chk("stream_drained", 32'(q_if.count), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 1'($urandom), $urandom, $urandom, ($urandom_range(0, 2) != 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
